// File: rtl/time_set_editor_pkg.sv
// Shared definitions for the time-set editor: FSM state encoding, field
// selector encodings and the BCD maxima of the three time fields.
package time_set_editor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] FIELD_HH = 2'd0;
  localparam logic [1:0] FIELD_MM = 2'd1;
  localparam logic [1:0] FIELD_SS = 2'd2;
  localparam int         NUM_FIELDS = 3;

  localparam logic [7:0] BCD_HOUR_MAX   = 8'h23;
  localparam logic [7:0] BCD_MINSEC_MAX = 8'h59;

endpackage

// File: rtl/time_set_editor_bcd_field_counter.sv
// bcd_field_counter: one two-digit BCD field with wrap at MAX.
//   clk, reset : clock, synchronous active-high reset (value -> 8'h00)
//   load       : capture load_val (highest priority, stored as-is)
//   inc, dec   : step +1 / -1 in BCD; both together leave value unchanged
//   value      : registered BCD value
module bcd_field_counter #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] value
);

  logic [7:0] nxt_up, nxt_dn;

  always_comb begin
    // At or above MAX wraps to zero, so an out-of-range loaded value
    // recovers on its first increment.
    nxt_up = 8'h00;
    if (value < MAX) begin
      if (value[3:0] >= 4'd9) nxt_up = {value[7:4] + 4'd1, 4'd0};
      else                    nxt_up = value + 8'd1;
    end
    nxt_dn = MAX;
    if (value != 8'h00) begin
      if (value[3:0] == 4'd0) nxt_dn = {value[7:4] - 4'd1, 4'd9};
      else                    nxt_dn = value - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)             value <= 8'h00;
    else if (load)         value <= load_val;
    else if (inc && !dec)  value <= nxt_up;
    else if (dec && !inc)  value <= nxt_dn;
  end

endmodule

// File: rtl/time_set_editor.sv
// time_set_editor: button-driven editor for an hh:mm:ss BCD time.
//   clk, reset          : clock, synchronous active-high reset
//   edit_en             : level, high requests edit mode
//   pulse_up/down       : +1 / -1 on the selected field (EDIT only)
//   pulse_left/right    : move field selection (EDIT only)
//   load, load_hh/mm/ss : capture the current time (IDLE only)
//   hh, mm, ss          : registered edited time in BCD
//   field_sel           : 0 hours, 1 minutes, 2 seconds
//   editing, commit     : high in EDIT / one-cycle strobe in COMMIT
module time_set_editor
  import time_set_editor_pkg::*;
#(
  parameter logic [7:0] HOUR_MAX   = BCD_HOUR_MAX,
  parameter logic [7:0] MINSEC_MAX = BCD_MINSEC_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       edit_en,
  input  logic       pulse_up,
  input  logic       pulse_down,
  input  logic       pulse_left,
  input  logic       pulse_right,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic [1:0] field_sel,
  output logic       editing,
  output logic       commit
);

  state_t     state, state_nxt;
  logic [1:0] sel_nxt;

  logic [NUM_FIELDS-1:0][7:0] load_vals, vals;

  assign load_vals = {load_ss, load_mm, load_hh};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      field_sel <= FIELD_HH;
    end else begin
      state     <= state_nxt;
      field_sel <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = field_sel;
    case (state)
      IDLE: if (edit_en) begin
        state_nxt = EDIT;
        sel_nxt   = FIELD_HH;
      end
      EDIT: begin
        if (!edit_en) state_nxt = COMMIT;
        if (pulse_right && !pulse_left)
          sel_nxt = (field_sel == FIELD_SS) ? FIELD_HH : field_sel + 2'd1;
        else if (pulse_left && !pulse_right)
          sel_nxt = (field_sel == FIELD_HH) ? FIELD_SS : field_sel - 2'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign editing = (state == EDIT);
  assign commit  = (state == COMMIT);

  // Value pulses use the registered field_sel, i.e. the field selected
  // before any simultaneous move.
  for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
    localparam logic [7:0] FMAX = (f == 0) ? HOUR_MAX : MINSEC_MAX;
    logic hit;
    assign hit = editing && (field_sel == 2'(f));

    bcd_field_counter #(.MAX(FMAX)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     ((state == IDLE) && load),
      .load_val (load_vals[f]),
      .inc      (hit && pulse_up),
      .dec      (hit && pulse_down),
      .value    (vals[f])
    );
  end

  assign hh = vals[0];
  assign mm = vals[1];
  assign ss = vals[2];

endmodule

// File: tb/tb_time_set_editor.sv
module tb_time_set_editor;

  logic       clk = 1'b0;
  logic       reset, edit_en, pulse_up, pulse_down, pulse_left, pulse_right, load;
  logic [7:0] load_hh, load_mm, load_ss;
  logic [7:0] hh, mm, ss;
  logic [1:0] field_sel;
  logic       editing, commit;

  typedef struct packed {
    logic [7:0] hh, mm, ss;
    logic [1:0] fs;
    logic       ed, cm;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  time_set_editor dut (
    .clk(clk), .reset(reset), .edit_en(edit_en),
    .pulse_up(pulse_up), .pulse_down(pulse_down),
    .pulse_left(pulse_left), .pulse_right(pulse_right),
    .load(load), .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .hh(hh), .mm(mm), .ss(ss), .field_sel(field_sel),
    .editing(editing), .commit(commit)
  );

  always #5 clk = ~clk;

  // Monitor: the expectation pushed before an edge is checked just after it.
  always @(posedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      exp_t  a;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      #1;
      a = '{hh: hh, mm: mm, ss: ss, fs: field_sel, ed: editing, cm: commit};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got hh=%h mm=%h ss=%h fs=%0d ed=%b cm=%b, want hh=%h mm=%h ss=%h fs=%0d ed=%b cm=%b",
                 n, a.hh, a.mm, a.ss, a.fs, a.ed, a.cm, e.hh, e.mm, e.ss, e.fs, e.ed, e.cm);
      end
    end
  end

  // ctl = {reset, edit_en, up, down, left, right, load}
  task automatic step(input logic [6:0] ctl, input logic [23:0] ld,
                      input logic [23:0] eh, input logic [1:0] efs,
                      input logic eed, input logic ecm, input string nm);
    @(negedge clk);
    {reset, edit_en, pulse_up, pulse_down, pulse_left, pulse_right, load} = ctl;
    {load_hh, load_mm, load_ss} = ld;
    exp_q.push_back('{hh: eh[23:16], mm: eh[15:8], ss: eh[7:0], fs: efs, ed: eed, cm: ecm});
    name_q.push_back(nm);
  endtask

  localparam logic [6:0] RST = 7'b1000000, EN = 7'b0100000, UP = 7'b0010000,
                         DN  = 7'b0001000, LF = 7'b0000100, RT = 7'b0000010,
                         LD  = 7'b0000001, NONE = 7'b0;

  initial begin
    {reset, edit_en, pulse_up, pulse_down, pulse_left, pulse_right, load} = '0;
    {load_hh, load_mm, load_ss} = '0;

    step(RST,          24'h0,      24'h000000, 2'd0, 0, 0, "reset");
    step(LD,           24'h123456, 24'h123456, 2'd0, 0, 0, "idle_load");
    step(UP|RT,        24'h0,      24'h123456, 2'd0, 0, 0, "idle_pulse_ignored");
    step(LD,           24'h230959, 24'h230959, 2'd0, 0, 0, "idle_load2");
    step(EN,           24'h0,      24'h230959, 2'd0, 1, 0, "enter_edit");
    step(EN|UP,        24'h0,      24'h000959, 2'd0, 1, 0, "hh_wrap_up");
    step(EN|DN,        24'h0,      24'h230959, 2'd0, 1, 0, "hh_wrap_down");
    step(EN|LD,        24'h111111, 24'h230959, 2'd0, 1, 0, "edit_load_ignored");
    step(EN|RT,        24'h0,      24'h230959, 2'd1, 1, 0, "right_to_mm");
    step(EN|UP,        24'h0,      24'h231059, 2'd1, 1, 0, "mm_carry");
    step(EN|DN,        24'h0,      24'h230959, 2'd1, 1, 0, "mm_borrow");
    step(EN|UP|DN,     24'h0,      24'h230959, 2'd1, 1, 0, "up_down_cancel");
    step(EN|LF|RT,     24'h0,      24'h230959, 2'd1, 1, 0, "left_right_cancel");
    step(EN|LF,        24'h0,      24'h230959, 2'd0, 1, 0, "left_to_hh");
    step(EN|LF,        24'h0,      24'h230959, 2'd2, 1, 0, "left_wrap");
    step(EN|UP,        24'h0,      24'h230900, 2'd2, 1, 0, "ss_wrap_up");
    step(EN|DN,        24'h0,      24'h230959, 2'd2, 1, 0, "ss_wrap_down");
    step(EN|RT,        24'h0,      24'h230959, 2'd0, 1, 0, "right_wrap");
    step(EN|LF,        24'h0,      24'h230959, 2'd2, 1, 0, "left_again");
    step(NONE,         24'h0,      24'h230959, 2'd2, 0, 1, "commit_pulse");
    step(NONE,         24'h0,      24'h230959, 2'd2, 0, 0, "commit_one_cycle");
    step(DN,           24'h0,      24'h230959, 2'd2, 0, 0, "idle_pulse_ignored2");
    step(LD,           24'h054500, 24'h054500, 2'd2, 0, 0, "idle_load3");
    step(EN,           24'h0,      24'h054500, 2'd0, 1, 0, "entry_sel_zero");
    step(EN|UP|RT,     24'h0,      24'h064500, 2'd1, 1, 0, "up_with_right");
    step(EN|DN|LF,     24'h0,      24'h064400, 2'd0, 1, 0, "down_with_left");
    step(RST|EN,       24'h0,      24'h000000, 2'd0, 0, 0, "reset_mid_edit");
    step(NONE,         24'h0,      24'h000000, 2'd0, 0, 0, "no_commit_after_reset");
    step(LD,           24'h300000, 24'h300000, 2'd0, 0, 0, "load_over_max");
    step(EN,           24'h0,      24'h300000, 2'd0, 1, 0, "enter_edit2");
    step(EN|UP,        24'h0,      24'h000000, 2'd0, 1, 0, "over_max_wraps");
    step(NONE,         24'h0,      24'h000000, 2'd0, 0, 1, "commit_pulse2");
    step(NONE,         24'h0,      24'h000000, 2'd0, 0, 0, "back_to_idle");

    @(negedge clk);
    {reset, edit_en, pulse_up, pulse_down, pulse_left, pulse_right, load} = '0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
